// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared types and defaults for the memory responder slice:
//   state_t  - responder FSM state (IDLE / BUSY / RESP)
//   word_t   - 32-bit data word
//   be_t     - 4-bit byte-enable mask, bit i covers word[8i+7:8i]
//   DEFAULT_DEPTH_WORDS / DEFAULT_LATENCY - default parameter values
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_LATENCY     = 2;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Word-addressed storage built from four independent byte lanes so each
// lane maps onto its own block RAM with a synchronous write and a
// registered read. No reset: contents survive a responder reset.
// Ports:
//   clk      - clock, rising edge
//   i_we     - write strobe (qualified per lane by i_be)
//   i_re     - read strobe; o_rdata updates on the following edge only
//   i_idx    - word index
//   i_wdata  - write data
//   i_be     - byte enables
//   o_rdata  - registered read data, held between reads
module mem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  word_t         i_wdata,
  input  be_t           i_be,
  output word_t         o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH_WORDS];
      logic [7:0] r_rd;

      always_ff @(posedge clk) begin
        if (i_we && i_be[gi]) begin
          r_lane[i_idx] <= i_wdata[8*gi +: 8];
        end
        if (i_re) begin
          r_rd <= r_lane[i_idx];
        end
      end

      assign o_rdata[8*gi +: 8] = r_rd;
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Single-outstanding memory responder: accepts one request in IDLE,
// spends LATENCY cycles in BUSY, performs the access on the BUSY->RESP
// edge and holds the response in RESP until the initiator takes it.
// Optional feature macro: MEM_ERR_CHECK_EN (alignment / range errors).
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   req_valid  - request present          req_ready - accepting (IDLE only)
//   req_wr     - 1 store / 0 load         req_addr  - byte address
//   req_wdata  - store data               req_be    - store byte enables
//   resp_valid - response present (RESP)  resp_ready - response taken
//   resp_rdata - load data, 0 for stores  resp_err  - access error
module mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;

  logic        r_wr;
  logic [31:0] r_addr;
  word_t       r_wdata;
  be_t         r_be;
  // r_rd_sel gates the array output: 0 for stores and erroring loads,
  // which makes resp_rdata read as 0 without touching the RAM register.
  logic        r_rd_sel;
  logic        r_err;

  logic        w_accept;
  logic        w_done;
  logic        w_err;
  logic        w_we;
  logic        w_re;
  word_t       w_mem_rdata;

  // Gated by rst so the initiator sees "not ready" while reset is held.
  assign req_ready  = rst && (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign w_accept   = req_valid && req_ready;
  assign w_done     = (r_state == BUSY) && (r_cnt == 4'd0);

`ifdef MEM_ERR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  logic w_misaligned;
  logic w_out_of_range;
  // A store with no enabled bytes touches nothing, so alignment is moot.
  assign w_misaligned   = (r_addr[1:0] != 2'b00) && (!r_wr || (r_be != 4'h0));
  assign w_out_of_range = ({1'b0, r_addr} >= ADDR_LIMIT);
  assign w_err          = w_misaligned || w_out_of_range;
  assign resp_err       = r_err;
`else
  logic w_unused_bits;
  assign w_err         = 1'b0;
  assign resp_err      = 1'b0;
  assign w_unused_bits = ^{r_addr[31:AW+2], r_addr[1:0], r_err};
`endif

  assign w_we       = w_done && r_wr && !w_err;
  assign w_re       = w_done && !r_wr;
  assign resp_rdata = r_rd_sel ? w_mem_rdata : 32'h0;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = BUSY;
          w_cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_rd_sel <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_done) begin
        r_rd_sel <= !r_wr && !w_err;
        r_err    <= w_err;
      end
    end
  end

  // Request capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr    <= req_wr;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_idx  (r_addr[AW+1:2]),
    .i_wdata(r_wdata),
    .i_be   (r_be),
    .o_rdata(w_mem_rdata)
  );

endmodule
